// File: rtl/rv_dec_pkg.sv
// RV32I decode constants, field encodings and the packed control bundle
// shared by the LUT, the pipelined decoder top and anything downstream.
package rv_dec_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10, RES_U = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    ST_W = 2'b00, ST_B = 2'b01, ST_H = 2'b10
  } store_e;

  typedef enum logic [2:0] {
    LD_B = 3'b000, LD_H = 3'b001, LD_W = 3'b010, LD_BU = 3'b011, LD_HU = 3'b100
  } load_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00, ALU_BR = 2'b01, ALU_FUNCT = 2'b10, ALU_MUL = 2'b11
  } alu_op_e;

  // Field order is MSB first; the offsets below must track it.
  typedef struct packed {
    logic        reg_write;
    imm_src_e    imm_src;
    logic        alu_src;
    logic        mem_write;
    result_src_e result_src;
    logic        branch;
    alu_op_e     alu_op;
    logic        jump;
    store_e      store;
    load_e       load;
    logic        jalr;
    logic        u_pc;
    logic [2:0]  br_cond;
    logic        illegal;
  } ctrl_t;

  localparam int CTRL_W = 23;

  localparam int OFF_ILLEGAL    = 0;
  localparam int OFF_BR_COND    = 1;
  localparam int OFF_U_PC       = 4;
  localparam int OFF_JALR       = 5;
  localparam int OFF_LOAD       = 6;
  localparam int OFF_STORE      = 9;
  localparam int OFF_JUMP       = 11;
  localparam int OFF_ALU_OP     = 12;
  localparam int OFF_BRANCH     = 14;
  localparam int OFF_RESULT_SRC = 15;
  localparam int OFF_MEM_WRITE  = 17;
  localparam int OFF_ALU_SRC    = 18;
  localparam int OFF_IMM_SRC    = 19;
  localparam int OFF_REG_WRITE  = 22;

  // Canonical illegal entry: every control field zero except the flag.
  function automatic ctrl_t illegal_ctrl();
    ctrl_t c;
    c = '0;
    c.illegal = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/rv_ctrl_lut.sv
// Combinational RV32I instruction-to-control-bundle lookup.
// RV32M decode is enabled by defining DECODER_MEXT_EN.
module rv_ctrl_lut
  import rv_dec_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output ctrl_t      o_ctrl
);

  ctrl_t w_dec;
  logic  w_ill;

  // Decode by opcode; any unsupported sub-encoding raises w_ill.
  always_comb begin
    w_dec      = '0;
    w_dec.load = LD_W;
    w_ill      = 1'b0;
    case (i_opcode)
      OP_LOAD: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.result_src = RES_MEM;
        case (i_funct3)
          3'b000:  w_dec.load = LD_B;
          3'b001:  w_dec.load = LD_H;
          3'b010:  w_dec.load = LD_W;
          3'b100:  w_dec.load = LD_BU;
          3'b101:  w_dec.load = LD_HU;
          default: w_ill = 1'b1;
        endcase
      end
      OP_STORE: begin
        w_dec.mem_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.imm_src   = IMM_S;
        case (i_funct3)
          3'b000:  w_dec.store = ST_B;
          3'b001:  w_dec.store = ST_H;
          3'b010:  w_dec.store = ST_W;
          default: w_ill = 1'b1;
        endcase
      end
      OP_R: begin
        w_dec.reg_write = 1'b1;
        if ((i_funct7 == F7_BASE) || (i_funct7 == F7_ALT)) begin
          w_dec.alu_op = ALU_FUNCT;
        end else if (i_funct7 == F7_MEXT) begin
`ifdef DECODER_MEXT_EN
          w_dec.alu_op = ALU_MUL;
`else
          w_ill = 1'b1;
`endif
        end else begin
          w_ill = 1'b1;
        end
      end
      OP_BRANCH: begin
        w_dec.branch  = 1'b1;
        w_dec.imm_src = IMM_B;
        w_dec.alu_op  = ALU_BR;
        w_dec.br_cond = i_funct3;
        if ((i_funct3 == 3'b010) || (i_funct3 == 3'b011)) begin
          w_ill = 1'b1;
        end else begin
          w_ill = 1'b0;
        end
      end
      OP_IALU: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_op    = ALU_FUNCT;
      end
      OP_JALR: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.result_src = RES_PC4;
        w_dec.jalr       = 1'b1;
        if (i_funct3 != 3'b000) begin
          w_ill = 1'b1;
        end else begin
          w_ill = 1'b0;
        end
      end
      OP_JAL: begin
        w_dec.reg_write  = 1'b1;
        w_dec.imm_src    = IMM_J;
        w_dec.result_src = RES_PC4;
        w_dec.jump       = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        w_dec.reg_write  = 1'b1;
        w_dec.imm_src    = IMM_U;
        w_dec.result_src = RES_U;
        w_dec.u_pc       = (i_opcode == OP_AUIPC);
      end
      default: w_ill = 1'b1;
    endcase
  end

  // Illegal encodings collapse to a single deterministic bundle.
  always_comb begin
    if (w_ill) begin
      o_ctrl = illegal_ctrl();
    end else begin
      o_ctrl = w_dec;
    end
  end

endmodule

// File: rtl/pipelined_main_decoder.sv
// Flow-controlled RV32I main decoder: decode at push, DEPTH-entry output FIFO,
// flush, saturating illegal counter. RV32M via DECODER_MEXT_EN (in rv_ctrl_lut).
module pipelined_main_decoder
  import rv_dec_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 2,
  parameter int ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [31:0]          out_instr,
  output logic [XLEN-1:0]      out_pc,
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  ctrl_t                 w_dec_ctrl;
  logic                  w_push;
  logic                  w_pop;
  logic [PTR_W-1:0]      w_wr_next;
  logic [PTR_W-1:0]      w_rd_next;
  logic [CNT_W-1:0]      w_count_next;

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_in_ready;
  logic [ILL_CNT_W-1:0]  r_ill_count;
  ctrl_t                 r_mem_ctrl  [DEPTH];
  logic [31:0]           r_mem_instr [DEPTH];
  logic [XLEN-1:0]       r_mem_pc    [DEPTH];

  rv_ctrl_lut u_lut (
    .i_opcode (in_instr[6:0]),
    .i_funct3 (in_instr[14:12]),
    .i_funct7 (in_instr[31:25]),
    .o_ctrl   (w_dec_ctrl)
  );

  // Handshake qualification and next-state for pointers and occupancy.
  always_comb begin
    w_push    = in_valid & r_in_ready;
    w_pop     = (r_count != '0) & out_ready;
    w_wr_next = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1'b1);
    w_rd_next = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1'b1);
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1'b1);
      2'b01:   w_count_next = r_count - CNT_W'(1'b1);
      default: w_count_next = r_count;
    endcase
  end

  // FIFO control; in_ready is registered so it never depends on out_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_next;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next < FULL_CNT);
    end
  end

  // Entry storage; cleared on reset so the outputs read zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_ctrl[i]  <= '0;
        r_mem_instr[i] <= '0;
        r_mem_pc[i]    <= '0;
      end
    end else if (w_push && !flush) begin
      r_mem_ctrl[r_wr_ptr]  <= w_dec_ctrl;
      r_mem_instr[r_wr_ptr] <= in_instr;
      r_mem_pc[r_wr_ptr]    <= in_pc;
    end
  end

  // Saturating illegal counter; a push discarded by flush is not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ill_count <= '0;
    end else if (w_push && !flush && w_dec_ctrl.illegal &&
                 (r_ill_count != {ILL_CNT_W{1'b1}})) begin
      r_ill_count <= r_ill_count + ILL_CNT_W'(1'b1);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_count != '0);
  assign out_ctrl  = r_mem_ctrl[r_rd_ptr];
  assign out_instr = r_mem_instr[r_rd_ptr];
  assign out_pc    = r_mem_pc[r_rd_ptr];
  assign ill_count = r_ill_count;

endmodule

// File: tb/tb_pipelined_main_decoder.sv
// Self-checking bench for pipelined_main_decoder: constant vector table,
// hand sequences for backpressure/flush/reset, and a randomized queue model.
module tb_pipelined_main_decoder;

  localparam int DEPTH = 2;
  localparam int ICW   = 2;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, out_instr, in_pc, out_pc;
  logic [22:0] out_ctrl;
  logic [ICW-1:0] ill_count;

  int n_checks = 0;
  int n_pass   = 0;

  pipelined_main_decoder #(.XLEN(32), .DEPTH(DEPTH), .ILL_CNT_W(ICW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_instr(out_instr), .out_pc(out_pc), .ill_count(ill_count)
  );

  always #5 clk = ~clk;

  localparam logic [22:0] ILL = 23'h000001;

  // Bundle in field order: rw imm asrc mw res br aop j st ld jalr upc bc ill
  function automatic logic [22:0] mk(input logic rw, input logic [2:0] imm, input logic asrc,
      input logic mw, input logic [1:0] res, input logic br, input logic [1:0] aop,
      input logic j, input logic [1:0] st, input logic [2:0] ld, input logic jr,
      input logic upc, input logic [2:0] bc);
    return {rw, imm, asrc, mw, res, br, aop, j, st, ld, jr, upc, bc, 1'b0};
  endfunction

  // Reference decode from the instruction-set rules.
  function automatic logic [22:0] ref_ctrl(input logic [31:0] ins);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (ins[6:0])
      7'h03: begin
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return ILL;
        return mk(1'b1, 3'd0, 1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0,
                  (f3 == 3'd4) ? 3'd3 : (f3 == 3'd5) ? 3'd4 : f3, 1'b0, 1'b0, 3'd0);
      end
      7'h23: begin
        if (f3 >= 3'd3) return ILL;
        return mk(1'b0, 3'd1, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0,
                  (f3 == 3'd0) ? 2'd1 : (f3 == 3'd1) ? 2'd2 : 2'd0, 3'd2, 1'b0, 1'b0, 3'd0);
      end
      7'h33: begin
        if (f7 == 7'h00 || f7 == 7'h20)
          return mk(1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 2'd0, 3'd2, 1'b0, 1'b0, 3'd0);
`ifdef DECODER_MEXT_EN
        if (f7 == 7'h01)
          return mk(1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 2'd0, 3'd2, 1'b0, 1'b0, 3'd0);
`endif
        return ILL;
      end
      7'h63: begin
        if (f3 == 3'd2 || f3 == 3'd3) return ILL;
        return mk(1'b0, 3'd2, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 2'd0, 3'd2, 1'b0, 1'b0, f3);
      end
      7'h13: return mk(1'b1, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 2'd0, 3'd2, 1'b0, 1'b0, 3'd0);
      7'h67: begin
        if (f3 != 3'd0) return ILL;
        return mk(1'b1, 3'd0, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 3'd2, 1'b1, 1'b0, 3'd0);
      end
      7'h6F: return mk(1'b1, 3'd3, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 1'b1, 2'd0, 3'd2, 1'b0, 1'b0, 3'd0);
      7'h37: return mk(1'b1, 3'd4, 1'b0, 1'b0, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0, 3'd2, 1'b0, 1'b0, 3'd0);
      7'h17: return mk(1'b1, 3'd4, 1'b0, 1'b0, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0, 3'd2, 1'b0, 1'b1, 3'd0);
      default: return ILL;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [22:0] ctrl;
  } vec_t;

  typedef struct {
    logic [22:0] c;
    logic [31:0] i;
    logic [31:0] p;
  } ent_t;

  vec_t vecs[$];
  ent_t q[$];

  initial begin
    logic [22:0] mul_exp;
    int          ill_exp;
    logic [6:0]  opcs [10];
    logic [31:0] r;
    logic        exp_push, exp_pop;

    // Reset state, checked while reset is still asserted.
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_ill_count", 64'(ill_count), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    do_reset();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

`ifdef DECODER_MEXT_EN
    mul_exp = mk(1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 2'd0, 3'd2, 1'b0, 1'b0, 3'd0);
`else
    mul_exp = ILL;
`endif
    vecs = '{
      '{32'h00812283, mk(1, 3'd0, 1, 0, 2'd1, 0, 2'd0, 0, 2'd0, 3'd2, 0, 0, 3'd0)}, // lw
      '{32'h00814283, mk(1, 3'd0, 1, 0, 2'd1, 0, 2'd0, 0, 2'd0, 3'd3, 0, 0, 3'd0)}, // lbu
      '{32'h00815283, mk(1, 3'd0, 1, 0, 2'd1, 0, 2'd0, 0, 2'd0, 3'd4, 0, 0, 3'd0)}, // lhu
      '{32'h00813283, ILL},
      '{32'h00512423, mk(0, 3'd1, 1, 1, 2'd0, 0, 2'd0, 0, 2'd0, 3'd2, 0, 0, 3'd0)}, // sw
      '{32'h00510423, mk(0, 3'd1, 1, 1, 2'd0, 0, 2'd0, 0, 2'd1, 3'd2, 0, 0, 3'd0)}, // sb
      '{32'h00511423, mk(0, 3'd1, 1, 1, 2'd0, 0, 2'd0, 0, 2'd2, 3'd2, 0, 0, 3'd0)}, // sh
      '{32'h00513423, ILL},
      '{32'h003100B3, mk(1, 3'd0, 0, 0, 2'd0, 0, 2'd2, 0, 2'd0, 3'd2, 0, 0, 3'd0)}, // add
      '{32'h403100B3, mk(1, 3'd0, 0, 0, 2'd0, 0, 2'd2, 0, 2'd0, 3'd2, 0, 0, 3'd0)}, // sub
      '{32'h203100B3, ILL},
      '{32'h0020E463, mk(0, 3'd2, 0, 0, 2'd0, 1, 2'd1, 0, 2'd0, 3'd2, 0, 0, 3'd6)}, // bltu
      '{32'h00208463, mk(0, 3'd2, 0, 0, 2'd0, 1, 2'd1, 0, 2'd0, 3'd2, 0, 0, 3'd0)}, // beq
      '{32'h00209463, mk(0, 3'd2, 0, 0, 2'd0, 1, 2'd1, 0, 2'd0, 3'd2, 0, 0, 3'd1)}, // bne
      '{32'h0020D463, mk(0, 3'd2, 0, 0, 2'd0, 1, 2'd1, 0, 2'd0, 3'd2, 0, 0, 3'd5)}, // bge
      '{32'h0020F463, mk(0, 3'd2, 0, 0, 2'd0, 1, 2'd1, 0, 2'd0, 3'd2, 0, 0, 3'd7)}, // bgeu
      '{32'h0020A463, ILL},
      '{32'h00510093, mk(1, 3'd0, 1, 0, 2'd0, 0, 2'd2, 0, 2'd0, 3'd2, 0, 0, 3'd0)}, // addi
      '{32'h000100E7, mk(1, 3'd0, 1, 0, 2'd2, 0, 2'd0, 0, 2'd0, 3'd2, 1, 0, 3'd0)}, // jalr
      '{32'h000110E7, ILL},
      '{32'h000000EF, mk(1, 3'd3, 0, 0, 2'd2, 0, 2'd0, 1, 2'd0, 3'd2, 0, 0, 3'd0)}, // jal
      '{32'h123450B7, mk(1, 3'd4, 0, 0, 2'd3, 0, 2'd0, 0, 2'd0, 3'd2, 0, 0, 3'd0)}, // lui
      '{32'h12345097, mk(1, 3'd4, 0, 0, 2'd3, 0, 2'd0, 0, 2'd0, 3'd2, 0, 1, 3'd0)}, // auipc
      '{32'h02208033, mul_exp},
      '{32'h0000007F, ILL}
    };

    // Table: one push per cycle with out_ready held, result visible next cycle.
    ill_exp = 0;
    out_ready = 1'b1;
    foreach (vecs[k]) begin
      in_valid = 1'b1;
      in_instr = vecs[k].instr;
      in_pc    = 32'h1000 + 32'(k) * 32'd4;
      tick();
      if (vecs[k].ctrl[0] && ill_exp < 3) ill_exp++;
      chk($sformatf("vec%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_ctrl", k), 64'(out_ctrl), 64'(vecs[k].ctrl));
      chk($sformatf("vec%0d_instr", k), 64'(out_instr), 64'(vecs[k].instr));
      chk($sformatf("vec%0d_pc", k), 64'(out_pc), 64'h1000 + 64'(k) * 64'd4);
      chk($sformatf("vec%0d_illcnt", k), 64'(ill_count), 64'(ill_exp));
    end
    in_valid = 1'b0;
    tick();
    chk("table_drained", 64'(out_valid), 64'd0);

    // Backpressure: two pushes fill the FIFO, the third waits for a pop.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00510093; in_pc = 32'hA0;
    tick();
    in_instr = 32'h003100B3; in_pc = 32'hA4;
    tick();
    in_instr = 32'h000000EF; in_pc = 32'hA8;
    chk("bp_full_in_ready", 64'(in_ready), 64'd0);
    chk("bp_head_pc", 64'(out_pc), 64'hA0);
    tick();
    chk("bp_stable_pc", 64'(out_pc), 64'hA0);
    chk("bp_stable_instr", 64'(out_instr), 64'h00510093);
    out_ready = 1'b1;
    tick();
    chk("bp_second_pc", 64'(out_pc), 64'hA4);
    chk("bp_ready_after_pop", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_third_pc", 64'(out_pc), 64'hA8);
    chk("bp_third_ctrl", 64'(out_ctrl), 64'(ref_ctrl(32'h000000EF)));
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Saturation with a 2-bit counter.
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h0000007F;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("sat%0d_ctrl", k), 64'(out_ctrl), 64'(ILL));
      chk($sformatf("sat%0d_count", k), 64'(ill_count), (k < 3) ? 64'(k + 1) : 64'd3);
    end
    in_valid = 1'b0;

    // Flush with a simultaneous illegal push, then asynchronous reset.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0000007F; in_pc = 32'hB0;
    tick();
    chk("fl_before_count", 64'(ill_count), 64'd1);
    flush = 1'b1; in_instr = 32'h0000107F;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    chk("fl_ill_count", 64'(ill_count), 64'd1);
    in_valid = 1'b1; in_instr = 32'h00812283; in_pc = 32'hC0;
    tick();
    in_valid = 1'b0;
    chk("fl_refill_pc", 64'(out_pc), 64'hC0);
    #1 reset = 1'b1;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd0);
    chk("ar_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("ar_out_instr", 64'(out_instr), 64'd0);
    chk("ar_out_pc", 64'(out_pc), 64'd0);
    chk("ar_ill_count", 64'(ill_count), 64'd0);

    // Randomized traffic against the queue model.
    do_reset();
    q.delete();
    ill_exp = 0;
    opcs = '{7'h03, 7'h23, 7'h33, 7'h63, 7'h13, 7'h67, 7'h6F, 7'h37, 7'h17, 7'h7F};
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      r[6:0] = opcs[$urandom_range(0, 9)];
      if (r[6:0] == 7'h33) r[31:25] = ($urandom_range(0, 2) == 0) ? 7'h00 :
                                      ($urandom_range(0, 1) == 0) ? 7'h20 : 7'h01;
      in_instr  = r;
      in_pc     = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      exp_push  = in_valid && (q.size() < DEPTH);
      exp_pop   = (q.size() != 0) && out_ready;
      tick();
      if (flush) begin
        q.delete();
      end else begin
        if (exp_pop) void'(q.pop_front());
        if (exp_push) begin
          q.push_back('{ref_ctrl(r), r, in_pc});
          if (ref_ctrl(r) == ILL && ill_exp < 3) ill_exp++;
        end
      end
      chk("rnd_in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      chk("rnd_out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("rnd_ill_count", 64'(ill_count), 64'(ill_exp));
      if (q.size() != 0) begin
        chk("rnd_ctrl", 64'(out_ctrl), 64'(q[0].c));
        chk("rnd_instr", 64'(out_instr), 64'(q[0].i));
        chk("rnd_pc", 64'(out_pc), 64'(q[0].p));
      end
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case the sequence above stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
